encoder_system_medium_decoder: RTL and testbench
================================================

// Module: encoder_system_medium_decoder
// PURPOSE
// - End-to-end ECC link: 8-bit data is SECDED-encoded (Hamming(12,8) + overall parity = 13-bit codeword),
//   sent through a simulated noisy medium that may flip one codeword bit per cycle, then decoded and corrected.
// - Lets the team show, and check in a bench, that single-bit channel errors never reach the data output.
// - Self-contained top level with no external memory or handshake.
// PARAMETERS
// - DATA_W   8        payload width; fixed, and the codeword layout below depends on it
// - CW_W     13       codeword width: 4 Hamming parity bits, 8 data bits, 1 overall parity bit
// - LFSR_SEED 7'h01   reset value of the noise LFSR; must be non-zero
// PORTS
// - clk        in   1  system clock; everything is on the rising edge
// - reset      in   1  synchronous, active-high reset
// - noise_off  in   1  1 = medium passes the codeword unchanged; 0 = medium may inject one bit flip per cycle
// - data_in    in   8  payload to transmit
// - data_out   out  8  corrected payload, registered
// - error      out  1  registered flag: 1 = the decoder detected a non-zero syndrome for the sample it just decoded
// BEHAVIOUR
// - Reset (sync, high): data_out=8'h00, error=0, noise LFSR=LFSR_SEED. Reset has priority over all other activity.
// - Latency: the encoder, the medium XOR and the syndrome/correct logic are combinational. data_out and error register
//   at the next rising edge, so latency is 1 cycle. data_in applied before edge N appears on data_out after edge N.
// - Codeword layout, Hamming positions 1..12 mapped to cw[12:1]:
//   - parity at positions 1, 2, 4, 8
//   - data d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12
//   - cw[0] = overall even parity of cw[12:1]
// - Parity bit at position 2^k = XOR of every data position whose index has bit k set (even parity).
// - Medium:
//   - rx_cw = cw ^ flip_mask.
//   - flip_mask = 0 when noise_off=1.
//   - Otherwise flip_mask = 1 << lfsr[3:0] when lfsr[3:0] < 13, and 0 when lfsr[3:0] >= 13.
// - Noise LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1. It steps every cycle when not in reset, whatever noise_off is.
// - Decoder:
//   - syndrome s[3:0] = recomputed parity XOR received parity; overall check p = XOR of all 13 received bits.
//   - s!=0, p=1: single error; flip the bit at position s (s in 1..12), then extract data.
//   - s==0, p=1: error in cw[0] only; data is already valid.
//   - s!=0, p=0: double error, uncorrectable; output the uncorrected data bits.
//     This case cannot arise from this medium.
//   - s > 12 with p=1: treat as uncorrectable; output the uncorrected data bits.
//   - error = (s!=0) | p, so error is 1 for any corrected or uncorrectable error.
// - With noise_off=1, error is always 0 after reset. With noise off or on, data_out equals data_in delayed 1 cycle.
// - Boundary cases:
//   - data_in 8'hFF -> 8'h00 wrap: no special handling.
//   - noise_off toggled mid-stream: takes effect in the same cycle, because the medium is combinational.
//   - reset mid-stream: outputs clear at that edge; data resumes 1 cycle after reset is released.
// STRUCTURE
// - Package ecc_link_pkg holds:
//   - the DATA_W and CW_W localparams and typedef logic [12:0] codeword_t
//   - functions hamming_encode(data)->codeword_t and hamming_syndrome(codeword_t)->logic [3:0]
// - One sub-module, secded_decoder: combinational input codeword_t; outputs data[7:0], err.
//   The top level instantiates it and registers its outputs.
// - Encoder, medium XOR and LFSR stay inline in the top level.
// TESTING
// - Reset: hold reset high 2 cycles -> data_out=8'h00, error=0. With noise_off=1 and data_in=0 held 200 cycles
//   -> data_out=0 and error=0 every cycle.
// - Clean sweep: noise_off=1, data_in steps 1..255 then 0, one new value every 2 cycles, checked 1 cycle after each
//   change -> data_out==data_in, error=0.
// - Noisy sweep: noise_off=0, same sweep -> data_out==data_in every check. error pulses on cycles where lfsr[3:0]<13.
// - Codeword check: hamming_encode(8'h01) has cw[3]=1, with parity bits at positions 1 and 2 set, so cw[0]=1.
//   Force a flip of each bit position 0..12 in turn -> data_out=8'h01, error=1.
// - Double error: force flips at positions 3 and 5 on data 8'hA5 -> error=1, and the uncorrected data appears on data_out.
// - Mid-stream reset: during the noisy sweep assert reset for 1 cycle -> data_out=0, error=0, LFSR=7'h01.
//   data is correct again 1 cycle after reset is released.

Source files
------------

// File: rtl/ecc_link_pkg.sv
// Shared types and SECDED Hamming(12,8)+parity helpers for the ECC link.
// Codeword bit n holds Hamming position n for n = 1..12; bit 0 holds overall even parity.
package ecc_link_pkg;

    localparam int DATA_W = 8;
    localparam int CW_W   = 13;

    typedef logic [CW_W-1:0] codeword_t;

    // Hamming position of each data bit d0..d7
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    function automatic codeword_t hamming_encode(input logic [DATA_W-1:0] data);
        codeword_t  cw;
        logic [3:0] par;
        cw  = '0;
        par = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cw[DATA_POS[i]] = data[i];
        end
        // Parity slots are still zero here, so they drop out of the XOR
        for (int k = 0; k < 4; k++) begin
            for (int pos = 1; pos <= 12; pos++) begin
                if (pos[k]) begin
                    par[k] = par[k] ^ cw[pos];
                end
            end
        end
        cw[1] = par[0];
        cw[2] = par[1];
        cw[4] = par[2];
        cw[8] = par[3];
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    // Includes the received parity bit in each group, giving recomputed ^ received
    function automatic logic [3:0] hamming_syndrome(input codeword_t cw);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int pos = 1; pos <= 12; pos++) begin
                if (pos[k]) begin
                    s[k] = s[k] ^ cw[pos];
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SECDED decoder: corrects single-bit errors and flags anything non-clean.
// Uncorrectable patterns (double errors, or syndrome outside 1..12) pass the raw data bits through.
module secded_decoder
    import ecc_link_pkg::*;
(
    input  codeword_t         cw,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [3:0] syndrome;
    logic       overall;
    codeword_t  fixed_cw;

    always_comb begin
        syndrome = hamming_syndrome(cw);
        overall  = ^cw;
        fixed_cw = cw;
        // Only an odd error count with an in-range syndrome is a correctable single flip
        if (overall && (syndrome != 4'd0) && (syndrome <= 4'd12)) begin
            fixed_cw[syndrome] = ~cw[syndrome];
        end
        err = (syndrome != 4'd0) | overall;
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
            assign data[gi] = fixed_cw[DATA_POS[gi]];
        end
    endgenerate

endmodule

// File: rtl/encoder_system_medium_decoder.sv
// ECC link top: encode data_in, pass it through an LFSR-driven single-flip medium, decode.
// Encoder, medium and decoder are combinational; data_out and error register with 1-cycle latency.
module encoder_system_medium_decoder
    import ecc_link_pkg::*;
#(
    parameter logic [6:0] LFSR_SEED = 7'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              noise_off,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              error
);

    logic [6:0]        lfsr_reg;
    logic [6:0]        lfsr_next;
    codeword_t         tx_cw;
    codeword_t         flip_mask;
    codeword_t         rx_cw;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic [DATA_W-1:0] data_out_reg;
    logic              error_reg;

    // Fibonacci x^7 + x^6 + 1, shifting toward the MSB
    assign lfsr_next = {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};

    always_comb begin
        tx_cw     = hamming_encode(data_in);
        flip_mask = '0;
        if (!noise_off && (lfsr_reg[3:0] < 4'd13)) begin
            flip_mask = codeword_t'(1) << lfsr_reg[3:0];
        end
        rx_cw = tx_cw ^ flip_mask;
    end

    secded_decoder u_decoder (
        .cw   (rx_cw),
        .data (dec_data),
        .err  (dec_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg     <= LFSR_SEED;
            data_out_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            lfsr_reg     <= lfsr_next;
            data_out_reg <= dec_data;
            error_reg    <= dec_err;
        end
    end

    assign data_out = data_out_reg;
    assign error    = error_reg;

endmodule

// File: tb/tb_encoder_system_medium_decoder.sv
// Self-checking bench for the ECC link: directed vector table, clean/noisy sweeps,
// mid-stream reset and direct decoder corner cases on a standalone decoder instance.
module tb_encoder_system_medium_decoder;
    import ecc_link_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       noise_off = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       error;

    always #5 clk = ~clk;

    encoder_system_medium_decoder #(.LFSR_SEED(7'h01)) dut (
        .clk       (clk),
        .reset     (reset),
        .noise_off (noise_off),
        .data_in   (data_in),
        .data_out  (data_out),
        .error     (error)
    );

    codeword_t  probe_cw = '0;
    logic [7:0] probe_data;
    logic       probe_err;

    secded_decoder u_probe (
        .cw   (probe_cw),
        .data (probe_data),
        .err  (probe_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference noise model: error expected whenever the medium flips any bit
    logic [6:0] m_lfsr = 7'h01;
    logic       exp_err = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_lfsr  <= 7'h01;
            exp_err <= 1'b0;
        end else begin
            exp_err <= !noise_off && (m_lfsr[3:0] < 4'd13);
            m_lfsr  <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
    end

    typedef struct {
        logic       rst;
        logic       noff;
        logic [7:0] din;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // LFSR low nibble seen by rows 2..8: 1,2,4,8,0,0,1 -> every noisy row flips a bit
        vecs[0] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'h5A, 8'h5A, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h81, 8'h81, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h7E, 8'h7E, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 8'h01, 8'h01, 1'b1};

        @(negedge clk);
        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            noise_off = vecs[i].noff;
            data_in   = vecs[i].din;
            @(negedge clk);
            $display("vec %0d rst=%0b noff=%0b din=%02h -> dout=%02h err=%0b",
                     i, vecs[i].rst, vecs[i].noff, vecs[i].din, data_out, error);
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].exp_e));
        end

        // Reset for 2 cycles, then idle clean link for 200 cycles
        reset = 1'b1; noise_off = 1'b1; data_in = 8'h00;
        repeat (2) begin
            @(negedge clk);
            check("reset_data", 32'(data_out), 32'h00);
            check("reset_err", 32'(error), 32'h0);
        end
        check("reset_lfsr", 32'(dut.lfsr_reg), 32'h01);
        reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            check("idle_data", 32'(data_out), 32'h00);
            check("idle_err", 32'(error), 32'h0);
        end
        $display("idle 200 cycles done: checks=%0d errors=%0d", checks, errors);

        // Clean sweep 1..255 then 0, two cycles per value
        noise_off = 1'b1;
        for (int v = 1; v <= 256; v++) begin
            data_in = 8'(v);
            repeat (2) begin
                @(negedge clk);
                check("clean_data", 32'(data_out), 32'(data_in));
                check("clean_err", 32'(error), 32'h0);
            end
        end
        $display("clean sweep done: checks=%0d errors=%0d", checks, errors);

        // Noisy sweep with a one-cycle reset in the middle
        noise_off = 1'b0;
        for (int v = 1; v <= 256; v++) begin
            data_in = 8'(v);
            if (v == 128) begin
                reset = 1'b1;
                @(negedge clk);
                $display("midreset din=%02h -> dout=%02h err=%0b lfsr=%02h",
                         data_in, data_out, error, dut.lfsr_reg);
                check("midreset_data", 32'(data_out), 32'h00);
                check("midreset_err", 32'(error), 32'h0);
                check("midreset_lfsr", 32'(dut.lfsr_reg), 32'h01);
                reset = 1'b0;
            end
            repeat (2) begin
                @(negedge clk);
                check("noisy_data", 32'(data_out), 32'(data_in));
                check("noisy_err", 32'(error), 32'(exp_err));
            end
        end
        $display("noisy sweep done: checks=%0d errors=%0d", checks, errors);

        // Hand-computed codewords
        check("enc_01", 32'(hamming_encode(8'h01)), 32'h000F);
        check("enc_A5", 32'(hamming_encode(8'hA5)), 32'h144E);

        probe_cw = 13'h000F;
        #1;
        $display("probe clean cw=%04h -> data=%02h err=%0b", probe_cw, probe_data, probe_err);
        check("probe_clean_data", 32'(probe_data), 32'h01);
        check("probe_clean_err", 32'(probe_err), 32'h0);

        for (int b = 0; b < 13; b++) begin
            probe_cw = 13'h000F ^ (13'h0001 << b);
            #1;
            $display("probe flip %0d cw=%04h -> data=%02h err=%0b", b, probe_cw, probe_data, probe_err);
            check($sformatf("flip%0d_data", b), 32'(probe_data), 32'h01);
            check($sformatf("flip%0d_err", b), 32'(probe_err), 32'h1);
        end

        // Positions 3 and 5 flipped on A5: d0 and d1 invert, left uncorrected
        probe_cw = 13'h144E ^ 13'h0028;
        #1;
        $display("probe double cw=%04h -> data=%02h err=%0b", probe_cw, probe_data, probe_err);
        check("double_data", 32'(probe_data), 32'hA6);
        check("double_err", 32'(probe_err), 32'h1);

        // Flips at 1, 4, 8: odd count with syndrome 13, out of range
        probe_cw = 13'h000F ^ 13'h0112;
        #1;
        $display("probe s13 cw=%04h -> data=%02h err=%0b", probe_cw, probe_data, probe_err);
        check("s13_data", 32'(probe_data), 32'h01);
        check("s13_err", 32'(probe_err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
